// File: rtl/display_arbiter.sv
// display_arbiter: frame-synchronous req/gnt sharing of a 4-digit 7-segment display with hex decode.
// Optional LEAD_ZERO_BLANK_EN blanks leading zero digits (digit 0 always shown).
module display_arbiter #(
    parameter int N     = 18,
    parameter int DWELL = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  req,
    input  logic [15:0] data0,
    input  logic [15:0] data1,
    output logic [1:0]  gnt,
    output logic [6:0]  sal,
    output logic [3:0]  an
);
    localparam int DW = $clog2(DWELL + 1);

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

    state_t        state, state_nxt;
    logic [N-1:0]  cnt;
    logic [15:0]   snap;
    logic [DW-1:0] dwell;
    logic          rr;
    logic          fb, full, blank;
    logic [1:0]    d;
    logic [3:0]    nib;

    function automatic logic [6:0] seg(input logic [3:0] h);
        logic [6:0] s;
        case (h)
            4'h0: s = 7'b0000001;
            4'h1: s = 7'b1001111;
            4'h2: s = 7'b0010010;
            4'h3: s = 7'b0000110;
            4'h4: s = 7'b1001100;
            4'h5: s = 7'b0100100;
            4'h6: s = 7'b0100000;
            4'h7: s = 7'b0001111;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0000100;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b1100000;
            4'hC: s = 7'b0110001;
            4'hD: s = 7'b1000010;
            4'hE: s = 7'b0110000;
            default: s = 7'b0111000;
        endcase
        return s;
    endfunction

    assign fb   = &cnt;
    assign full = dwell == DW'(DWELL);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: state_nxt = req == 2'b01 ? OWN0 : req == 2'b10 ? OWN1 :
                              req == 2'b11 ? (rr ? OWN1 : OWN0) : IDLE;
            OWN0: state_nxt = !req[0] ? (req[1] ? OWN1 : IDLE) : (req[1] && full) ? OWN1 : OWN0;
            OWN1: state_nxt = !req[1] ? (req[0] ? OWN0 : IDLE) : (req[0] && full) ? OWN0 : OWN1;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt   <= '0;
            state <= IDLE;
            gnt   <= 2'b00;
            snap  <= '0;
            dwell <= '0;
            rr    <= 1'b0;
        end else begin
            cnt <= cnt + 1'b1;
            if (fb) begin
                state <= state_nxt;
                gnt   <= {state_nxt == OWN1, state_nxt == OWN0};
                if (state_nxt != state)
                    dwell <= '0;
                else if (state != IDLE && !full)
                    dwell <= dwell + 1'b1;
                // rr points at whoever lost the most recent grant
                if (state_nxt != state && state_nxt != IDLE)
                    rr <= state_nxt == OWN0;
                if (state_nxt == OWN0)
                    snap <= data0;
                else if (state_nxt == OWN1)
                    snap <= data1;
            end
        end
    end

    assign d   = cnt[N-1:N-2];
    assign nib = 4'(snap >> {d, 2'b00});
`ifdef LEAD_ZERO_BLANK_EN
    assign blank = d != 2'd0 && (snap >> {d, 2'b00}) == 16'd0;
`else
    assign blank = 1'b0;
`endif
    assign an  = state == IDLE ? 4'b1111 : ~(4'b0001 << d);
    assign sal = (state == IDLE || blank) ? 7'b1111111 : seg(nib);
endmodule

// File: tb/tb_display_arbiter.sv
// tb_display_arbiter: directed checks of display_arbiter with N=4 (16-cycle frame), DWELL=2.
module tb_display_arbiter;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [1:0]  req = 2'b00;
    logic [15:0] data0 = '0, data1 = '0;
    logic [1:0]  gnt;
    logic [6:0]  sal;
    logic [3:0]  an;
    int tests = 0, fails = 0, c = 0;

    display_arbiter #(.N(4), .DWELL(2)) dut (
        .clk(clk), .reset(reset), .req(req), .data0(data0), .data1(data1),
        .gnt(gnt), .sal(sal), .an(an)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, c);
        end
    endtask

    // c counts rising edges since reset release, so the scan counter equals c % 16
    task automatic goto(input int t);
        while (c < t) begin
            @(posedge clk);
            c++;
        end
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("rst_gnt", 16'(gnt), 16'h0);
        check("rst_an", 16'(an), 16'hF);
        check("rst_sal", 16'(sal), 16'h7F);
        @(negedge clk);
        reset = 1'b1;
        c = 0;
    endtask

    task automatic digit(input string tag, input logic [3:0] ea, input logic [6:0] es);
        check({tag, "_an"}, 16'(an), 16'(ea));
        check({tag, "_sal"}, 16'(sal), 16'(es));
    endtask

    initial begin
        // reset, no requests: blank for 48 cycles
        do_reset();
        for (int i = 1; i <= 48; i++) begin
            goto(i);
            check("idle_gnt", 16'(gnt), 16'h0);
            check("idle_an", 16'(an), 16'hF);
            check("idle_sal", 16'(sal), 16'h7F);
        end

        // single grant of 12AF
        do_reset();
        goto(3);
        req = 2'b01; data0 = 16'h12AF;
        goto(15);
        check("sg_pre_fb", 16'(gnt), 16'h0);
        goto(16);
        check("sg_gnt", 16'(gnt), 16'h1);
        digit("sg_d0", 4'b1110, 7'b0111000);
        goto(20); digit("sg_d1", 4'b1101, 7'b0001000);
        goto(24); digit("sg_d2", 4'b1011, 7'b0010010);
        goto(28); digit("sg_d3", 4'b0111, 7'b1001111);

        // owner 0 releases at cnt=5 with no other requester
        goto(37);
        req = 2'b00;
        goto(47);
        check("rel_hold_gnt", 16'(gnt), 16'h1);
        digit("rel_hold", 4'b0111, 7'b1001111);
        goto(48);
        check("rel_gnt", 16'(gnt), 16'h0);
        digit("rel_blank", 4'b1111, 7'b1111111);

        // snapshot stability: data changes at cnt=6
        do_reset();
        req = 2'b01; data0 = 16'h1234;
        goto(16); digit("ss_d0", 4'b1110, 7'b1001100);
        goto(22);
        data0 = 16'h5678;
        goto(24); digit("ss_d2", 4'b1011, 7'b0010010);
        goto(28); digit("ss_d3", 4'b0111, 7'b1001111);
        goto(32); digit("ss_n0", 4'b1110, 7'b0000000);
        goto(36); digit("ss_n1", 4'b1101, 7'b0001111);
        goto(44); digit("ss_n3", 4'b0111, 7'b0100100);

        // contention from IDLE: 01 for 3 frames, 10 for 3 frames, then 01
        do_reset();
        req = 2'b11; data0 = 16'h0005; data1 = 16'hBEEF;
        goto(16);
        check("ct_gnt_a", 16'(gnt), 16'h1);
        digit("ct_d0_a", 4'b1110, 7'b0100100);
        goto(63); check("ct_gnt_a_end", 16'(gnt), 16'h1);
        goto(64);
        check("ct_gnt_b", 16'(gnt), 16'h2);
        digit("ct_d0_b", 4'b1110, 7'b0111000);
        goto(76); digit("ct_d3_b", 4'b0111, 7'b1100000);
        goto(111); check("ct_gnt_b_end", 16'(gnt), 16'h2);
        goto(112);
        check("ct_gnt_c", 16'(gnt), 16'h1);
        digit("lz5_d0", 4'b1110, 7'b0100100);
        goto(116);
`ifdef LEAD_ZERO_BLANK_EN
        digit("lz5_d1", 4'b1101, 7'b1111111);
        goto(124); digit("lz5_d3", 4'b0111, 7'b1111111);
`else
        digit("lz5_d1", 4'b1101, 7'b0000001);
        goto(124); digit("lz5_d3", 4'b0111, 7'b0000001);
`endif
        data0 = 16'h0000;
        goto(128);
        check("lz0_gnt", 16'(gnt), 16'h1);
        digit("lz0_d0", 4'b1110, 7'b0000001);
        goto(132);
`ifdef LEAD_ZERO_BLANK_EN
        digit("lz0_d1", 4'b1101, 7'b1111111);
`else
        digit("lz0_d1", 4'b1101, 7'b0000001);
`endif

        // asynchronous reset mid-ownership aborts immediately
        #2;
        reset = 1'b0;
        #1;
        check("ar_gnt", 16'(gnt), 16'h0);
        digit("ar", 4'b1111, 7'b1111111);
        @(negedge clk);
        reset = 1'b1;
        c = 0;
        goto(15);
        check("ar_no_gnt", 16'(gnt), 16'h0);
        goto(16);
        check("ar_regnt", 16'(gnt), 16'h1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/display_arbiter.md
# display_arbiter

Time-shares the 4-digit, common-anode 7-segment display between two requesters, each presenting a 16-bit hex value. The block owns the digit-scan counter, grants the display with a req/gnt handshake, and switches owners only on frame boundaries so no frame ever mixes two sources. It also performs hex-to-segment decoding. It sits between the application blocks (e.g. counter, stopwatch) and the board pins `sal`/`an`.

## Interface
- `N`, 18: scan counter width. Digit index = `cnt[N-1:N-2]`. Frame = 2^N cycles. Digit slot = 2^(N-2) cycles. Minimum 4.
- `DWELL`, 64: number of complete frames an owner keeps the display before a contending requester may take it. Minimum 1.

- `clk` in 1: single clock. All state changes on the rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `req` in 2: `req[i]` high means requester i wants the display. Level-sensitive.
- `data0` in 16: value from requester 0. Nibble 0 goes to the rightmost digit.
- `data1` in 16: value from requester 1.
- `gnt` out 2: one-hot-or-zero grant, registered.
- `sal` out 7: segments, active low. Bit 6 = A … bit 0 = G.
- `an` out 4: anodes, active low. `an[0]` is the rightmost digit.

## Operation
- States: IDLE, OWN0, OWN1. Registers:
  - `cnt[N-1:0]` scan counter.
  - `snap[15:0]` display snapshot.
  - `dwell` frame counter, saturates at DWELL.
  - `rr` round-robin pointer: the requester preferred on a tie.
- Frame boundary (FB): the edge on which `cnt` wraps from 2^N-1 to 0. The state, `gnt`, `snap` and `dwell` change only on an FB edge.
- IDLE, at FB:
  - If only one requester is active, grant it.
  - If both are active, grant requester `rr`.
  - If neither is active, stay in IDLE.
- OWNi, at FB:
  - `req[i]`=0: go to OWNj if `req[j]`=1, else go to IDLE.
  - `req[i]`=1 and `req[j]`=1 and `dwell`==DWELL: go to OWNj.
  - Otherwise stay in OWNi and increment `dwell` (saturating).
- On every grant change:
  - `dwell` is set to 0.
  - `rr` is set to the index of the requester not just granted.
- At every FB in an OWN state (including entry), `snap` loads the data of the next-state owner, sampled on that edge. In IDLE, `snap` holds its value.
- Digit d = `cnt[N-1:N-2]`.
  - `an` = 4'b1110, 4'b1101, 4'b1011, 4'b0111 for d = 0..3.
  - `sal` = decode(`snap[4d+3:4d]`).
- Decode table:
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110
  - 4=1001100, 5=0100100, 6=0100000, 7=0001111
  - 8=0000000, 9=0000100, A=0001000, b=1100000
  - C=0110001, d=1000010, E=0110000, F=0111000
- In IDLE: `an`=4'b1111 and `sal`=7'b1111111 (blank). `cnt` keeps running.
- A requester dropping `req` mid-frame keeps `gnt` and its display until the next FB.
- Data changes mid-frame are not displayed until the next FB.

## Timing
- Reset values (asynchronous, immediate):
  - `cnt`=0, state=IDLE, `gnt`=2'b00, `snap`=0, `dwell`=0, `rr`=0.
  - `an`=4'b1111, `sal`=7'b1111111.
- Reset asserted mid-frame or mid-ownership aborts immediately to the reset values. There is no grant until the first FB after release.
- Grant latency: up to 2^N cycles after `req` rises, always landing on an FB.
  - `gnt` and `snap` update on the same edge.
  - The new value shows in digit 0 on the first cycle of the new frame.
- `sal` and `an` are combinational from `cnt`, `snap` and the state. They are valid the same cycle as those registers.
- With both requesters always active, ownership alternates every DWELL+1 frames.

## Configuration
- `LEAD_ZERO_BLANK_EN` defined:
  - Digit d>0 is blanked (`sal`=7'b1111111, `an` unchanged) when `snap[15:4d]`==0.
  - Digit 0 is always shown.
- Undefined: all four digits are always decoded.

## Test plan
All scenarios use N=4 (frame 16 cycles, digit slot 4 cycles) and DWELL=2.
- Reset:
  - Hold `reset`=0 for 5 cycles, then release with `req`=00.
  - Expect `an`=1111, `sal`=1111111 and `gnt`=00 for 48 cycles.
- Single grant:
  - `req`=01 and `data0`=16'h12AF at cycle 3.
  - Expect `gnt`=01 at the first FB.
  - Digit slots then show `an`=1110/`sal`=0111000, 1101/0001000, 1011/0010010, 0111/1001111.
- Contention from IDLE:
  - `req`=11 after reset.
  - Expect `gnt`=01 at the first FB, 10 three frames later, then 01 three frames after that.
- Release mid-frame:
  - Owner 0 drops `req` at `cnt`=5, with `req[1]`=0.
  - Expect `gnt`=01 until the FB, then 00 and a blank display.
- Snapshot stability:
  - `data0` changes 16'h1234→16'h5678 at `cnt`=6.
  - Expect the rest of the frame to show 1234 and the next frame to show 5678.
- `LEAD_ZERO_BLANK_EN` (compiled in):
  - `data0`=16'h0005: expect digit 0 `sal`=0100100 and digits 1–3 `sal`=1111111.
  - `data0`=0: expect digit 0 `sal`=0000001.
